// File: rtl/uart_duplex.sv
// Full-duplex 8N1 UART: independent TX and RX engines on one clock.
// TX sends one byte per accepted strobe; RX keeps the last good byte.
module uart_duplex #(
    parameter int CLK_FREQ_HZ  = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_pin,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_pin,
    output logic [7:0] rx_data,
    output logic       rx_busy,
    output logic       tx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_pin_q, tx_pin_d;

    state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_s1_q, rx_s2_q, rx_prev_q;

    assign tx_pin  = tx_pin_q;
    assign tx_busy = (tx_state_q != S_IDLE);
    assign rx_data = rx_data_q;
    assign rx_busy = (rx_state_q != S_IDLE);

    // TX state, bit timer, shift register and registered line driver
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_pin_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_pin_q   <= tx_pin_d;
        end
    end

    // TX next state: the next line level is decided one cycle ahead
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pin_d   = tx_pin_q;
        case (tx_state_q)
            S_IDLE: begin
                tx_pin_d = 1'b1;
                if (tx_start) begin
                    tx_shift_d = tx_data;
                    tx_cnt_d   = '0;
                    tx_pin_d   = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_pin_d   = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_pin_d   = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_pin_d   = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // RX synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_pin;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // RX state, mid-bit timer, shift register and output byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // RX next state: arm on a falling edge, then sample at bit centres
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    if (rx_s2_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    if (rx_s2_q) begin
                        rx_data_d = rx_shift_q;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_duplex.sv
// Bench for uart_duplex: two instances cross-wired, A.tx feeds B.rx
// unless the bench takes over B's line to inject malformed frames.
module tb_uart_duplex;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_txs = 1'b0;
    logic [7:0] a_txd = 8'h00;
    logic       b_txs = 1'b0;
    logic [7:0] b_txd = 8'h00;
    logic       manual = 1'b0;
    logic       man_line = 1'b1;

    logic       a_tx, a_rx, a_rxb, a_txb;
    logic [7:0] a_rxd;
    logic       b_tx, b_rx, b_rxb, b_txb;
    logic [7:0] b_rxd;

    int total = 0;
    int bad = 0;
    logic [7:0] model_a = 8'h00;
    logic [7:0] model_b = 8'h00;

    assign b_rx = manual ? man_line : a_tx;
    assign a_rx = b_tx;

    always #5 clk = ~clk;

    uart_duplex #(.CLKS_PER_BIT(CPB)) u_a (
        .clk(clk), .reset(reset), .rx_pin(a_rx),
        .tx_start(a_txs), .tx_data(a_txd), .tx_pin(a_tx),
        .rx_data(a_rxd), .rx_busy(a_rxb), .tx_busy(a_txb)
    );

    uart_duplex #(.CLKS_PER_BIT(CPB)) u_b (
        .clk(clk), .reset(reset), .rx_pin(b_rx),
        .tx_start(b_txs), .tx_data(b_txd), .tx_pin(b_tx),
        .rx_data(b_rxd), .rx_busy(b_rxb), .tx_busy(b_txb)
    );

    // Line level of bit k (0..9) of an 8N1 frame carrying d
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return logic'((d >> (k - 1)) & 8'h01);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (a_tx !== 1'b1) begin
            bad++; $display("FAIL reset_tx_pin got=%b want=1", a_tx);
        end
        total++;
        if (a_txb !== 1'b0) begin
            bad++; $display("FAIL reset_tx_busy got=%b want=0", a_txb);
        end
        total++;
        if (b_rxb !== 1'b0) begin
            bad++; $display("FAIL reset_rx_busy got=%b want=0", b_rxb);
        end
        total++;
        if (a_rxd !== 8'h00 || b_rxd !== 8'h00) begin
            bad++;
            $display("FAIL reset_rx_data got=%h/%h want=00", a_rxd, b_rxd);
        end
        reset = 1'b0;
        model_a = 8'h00;
        model_b = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    // Send d from A; check every bit period, busy length, B's reception
    task automatic test_tx_frame(input logic [7:0] d);
        int a_cnt, b_cnt, bit_err;
        a_cnt = 0;
        b_cnt = 0;
        a_txd = d;
        a_txs = 1'b1;
        @(negedge clk);
        a_txs = 1'b0;
        a_txd = ~d;
        for (int k = 0; k < 10; k++) begin
            bit_err = 0;
            for (int c = 0; c < CPB; c++) begin
                if (a_tx !== frame_bit(d, k)) bit_err++;
                if (a_txb === 1'b1) a_cnt++;
                if (b_rxb === 1'b1) b_cnt++;
                @(negedge clk);
            end
            total++;
            if (bit_err != 0) begin
                bad++;
                $display("FAIL tx_bit d=%h bit=%0d wrong_cycles=%0d want=%b",
                         d, k, bit_err, frame_bit(d, k));
            end
        end
        for (int c = 0; c < 40; c++) begin
            if (a_txb === 1'b1) a_cnt++;
            if (b_rxb === 1'b1) b_cnt++;
            @(negedge clk);
        end
        model_b = d;
        total++;
        if (a_cnt != 10 * CPB) begin
            bad++;
            $display("FAIL tx_busy_len d=%h got=%0d want=%0d", d, a_cnt, 10 * CPB);
        end
        total++;
        if (b_cnt < 9 * CPB || b_cnt > 10 * CPB) begin
            bad++;
            $display("FAIL rx_busy_len d=%h got=%0d want~%0d", d, b_cnt, 19 * CPB / 2);
        end
        total++;
        if (b_rxd !== model_b || b_rxb !== 1'b0) begin
            bad++;
            $display("FAIL loopback_rx d=%h got=%h busy=%b want=%h",
                     d, b_rxd, b_rxb, model_b);
        end
    endtask

    task automatic send_manual(input logic [7:0] d, input logic stopv);
        for (int k = 0; k < 10; k++) begin
            man_line = (k == 9) ? stopv : frame_bit(d, k);
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic test_false_start();
        int cnt;
        logic seen;
        cnt = 0;
        seen = 1'b0;
        manual = 1'b1;
        man_line = 1'b1;
        repeat (8) @(negedge clk);
        man_line = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 4) man_line = 1'b1;
            if (b_rxb === 1'b1) begin
                seen = 1'b1;
                cnt++;
            end
            @(negedge clk);
        end
        total++;
        if (!seen || b_rxb !== 1'b0) begin
            bad++;
            $display("FAIL false_start_busy seen=%b end=%b want=1/0", seen, b_rxb);
        end
        total++;
        if (cnt < CPB / 2 - 1 || cnt > CPB / 2 + 1) begin
            bad++;
            $display("FAIL false_start_len got=%0d want~%0d", cnt, CPB / 2);
        end
        total++;
        if (b_rxd !== model_b) begin
            bad++;
            $display("FAIL false_start_data got=%h want=%h", b_rxd, model_b);
        end
    endtask

    task automatic test_framing_error();
        int busy_cnt;
        busy_cnt = 0;
        manual = 1'b1;
        man_line = 1'b1;
        repeat (4) @(negedge clk);
        send_manual(8'h55, 1'b0);
        for (int c = 0; c < 3 * CPB; c++) begin
            if (b_rxb === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        total++;
        if (busy_cnt != 0) begin
            bad++;
            $display("FAIL frame_err_retrigger busy_cycles=%0d want=0", busy_cnt);
        end
        total++;
        if (b_rxd !== model_b) begin
            bad++;
            $display("FAIL frame_err_data got=%h want=%h", b_rxd, model_b);
        end
        man_line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_manual(8'h3C, 1'b1);
        repeat (CPB) @(negedge clk);
        model_b = 8'h3C;
        total++;
        if (b_rxd !== model_b || b_rxb !== 1'b0) begin
            bad++;
            $display("FAIL frame_err_recover got=%h busy=%b want=%h",
                     b_rxd, b_rxb, model_b);
        end
        manual = 1'b0;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int second;
        second = 0;
        a_txd = 8'h41;
        a_txs = 1'b1;
        @(negedge clk);
        a_txs = 1'b0;
        repeat (40) @(negedge clk);
        a_txd = 8'h12;
        a_txs = 1'b1;
        @(negedge clk);
        a_txs = 1'b0;
        for (int c = 0; c < 300 && a_txb === 1'b1; c++) @(negedge clk);
        for (int c = 0; c < 12 * CPB; c++) begin
            if (a_txb === 1'b1) second++;
            @(negedge clk);
        end
        model_b = 8'h41;
        total++;
        if (second != 0) begin
            bad++;
            $display("FAIL busy_ignore_extra busy_cycles=%0d want=0", second);
        end
        total++;
        if (b_rxd !== model_b) begin
            bad++;
            $display("FAIL busy_ignore_data got=%h want=%h", b_rxd, model_b);
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        waited = 0;
        a_txd = 8'h41;
        a_txs = 1'b1;
        @(negedge clk);
        a_txs = 1'b0;
        while (a_txb === 1'b1 && waited < 400) begin
            waited++;
            @(negedge clk);
        end
        total++;
        if (waited != 10 * CPB) begin
            bad++;
            $display("FAIL b2b_first_len got=%0d want=%0d", waited, 10 * CPB);
        end
        model_b = 8'h41;
        total++;
        if (b_rxd !== model_b) begin
            bad++;
            $display("FAIL b2b_first_data got=%h want=%h", b_rxd, model_b);
        end
        a_txd = 8'h12;
        a_txs = 1'b1;
        @(negedge clk);
        a_txs = 1'b0;
        total++;
        if (a_tx !== 1'b0 || a_txb !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart pin=%b busy=%b want=0/1", a_tx, a_txb);
        end
        repeat (11 * CPB) @(negedge clk);
        model_b = 8'h12;
        total++;
        if (b_rxd !== model_b) begin
            bad++;
            $display("FAIL b2b_second_data got=%h want=%h", b_rxd, model_b);
        end
    endtask

    task automatic test_held_start(input logic [7:0] d);
        a_txd = d;
        a_txs = 1'b1;
        @(negedge clk);
        a_txd = ~d;
        repeat (20) @(negedge clk);
        a_txs = 1'b0;
        repeat (11 * CPB) @(negedge clk);
        model_b = d;
        total++;
        if (b_rxd !== model_b || a_txb !== 1'b0) begin
            bad++;
            $display("FAIL held_start got=%h busy=%b want=%h/0", b_rxd, a_txb, model_b);
        end
    endtask

    task automatic test_duplex(input logic [7:0] da, input logic [7:0] db);
        a_txd = da;
        b_txd = db;
        a_txs = 1'b1;
        b_txs = 1'b1;
        @(negedge clk);
        a_txs = 1'b0;
        b_txs = 1'b0;
        repeat (11 * CPB) @(negedge clk);
        model_b = da;
        model_a = db;
        total++;
        if (b_rxd !== model_b || a_rxd !== model_a) begin
            bad++;
            $display("FAIL duplex got=%h/%h want=%h/%h", a_rxd, b_rxd, model_a, model_b);
        end
    endtask

    task automatic test_reset_mid_tx();
        a_txd = 8'h00;
        a_txs = 1'b1;
        @(negedge clk);
        a_txs = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (a_tx !== 1'b1 || a_txb !== 1'b0 || b_rxb !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_tx pin=%b txb=%b rxb=%b want=1/0/0",
                     a_tx, a_txb, b_rxb);
        end
        model_a = 8'h00;
        model_b = 8'h00;
        total++;
        if (b_rxd !== model_b) begin
            bad++;
            $display("FAIL reset_mid_rx_data got=%h want=%h", b_rxd, model_b);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tx_frame(8'h41);
        test_tx_frame(8'h00);
        test_tx_frame(8'hFF);
        test_tx_frame(8'hA5);
        for (int i = 0; i < 4; i++) test_tx_frame(8'($urandom));
        test_false_start();
        test_framing_error();
        test_busy_ignore();
        test_back_to_back();
        test_held_start(8'($urandom));
        test_duplex(8'($urandom), 8'($urandom));
        test_reset_mid_tx();
        test_tx_frame(8'h5A);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_duplex.md
Name: uart_duplex

Overview:
Full-duplex 8N1 UART with independent transmitter and receiver sharing one clock and one baud-rate parameter. The transmitter serialises a byte on a single-cycle start strobe. The receiver deserialises bytes from an asynchronous serial line and holds the last good byte. The block sits between the system fabric and the board serial pins, and two instances can be wired tx_pin-to-rx_pin for loopback.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate
CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (434), clock cycles per bit; overridable directly, minimum 4

Ports:
clk  input  1  system clock, all logic on the rising edge
reset  input  1  asynchronous, active-high reset
rx_pin  input  1  serial receive line, idle high, asynchronous to clk
tx_start  input  1  single-cycle strobe: start transmitting tx_data
tx_data  input  8  byte to transmit, sampled on the cycle tx_start is accepted
tx_pin  output  1  serial transmit line, idle high
rx_data  output  8  last correctly framed received byte
rx_busy  output  1  high while a receive frame is in progress
tx_busy  output  1  high while a transmit frame is in progress

Behaviour:
- Reset, asynchronous and active-high: tx_pin=1, tx_busy=0, rx_busy=0, rx_data=8'h00; both FSMs go to IDLE and all counters clear. Reset mid-frame aborts that frame immediately.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. No parity.
- TX FSM states: IDLE -> START -> DATA(bit 0..7) -> STOP -> IDLE.
  - In IDLE, tx_start=1 latches tx_data into a shift register. On the next edge, tx_pin goes low and tx_busy goes high.
  - Each state holds for CLKS_PER_BIT cycles. tx_pin is registered, so it has no glitches.
  - After STOP completes, tx_busy drops. The total busy time is 10*CLKS_PER_BIT cycles.
  - tx_start is ignored while tx_busy=1. A new tx_start is accepted on the first cycle tx_busy=0, allowing back-to-back frames.
  - A tx_start held for multiple cycles starts only one frame per IDLE entry.
  - Changes to tx_data after acceptance do not affect the frame in flight.
- RX front end: a 2-flop synchroniser on rx_pin, reset to 1. All RX decisions use the synchronised signal.
- RX FSM states: IDLE -> START -> DATA(bit 0..7) -> STOP -> IDLE.
  - IDLE: a synchronised low moves the FSM to START and sets rx_busy=1.
  - START: the line is sampled at CLKS_PER_BIT/2 cycles. If it is high, this is a false start: return to IDLE, drop rx_busy, leave rx_data unchanged. If it is low, continue.
  - DATA: each bit is sampled at mid-bit, i.e. every CLKS_PER_BIT cycles after the start-bit centre, and shifted in LSB first.
  - STOP: sampled at mid stop bit. If it is 1, rx_data is updated with the assembled byte on that cycle. If it is 0 (framing error), the byte is discarded and rx_data is unchanged.
  - rx_busy drops on the same cycle as the stop-bit sample. The FSM returns to IDLE and is re-armed for the next falling edge at once.
  - A line held low continuously after a framing error does not retrigger until it returns high. IDLE requires a high-to-low transition.
- rx_data holds its value indefinitely between frames.
- TX and RX are fully independent and may run simultaneously.

Test Plan:
- Reset: assert reset for 10 cycles -> tx_pin=1, tx_busy=0, rx_busy=0, rx_data=8'h00. Assert reset mid-TX -> tx_pin returns to 1 asynchronously.
- TX 0x41, CLKS_PER_BIT=16, 1-cycle tx_start -> tx_pin bits 0,1,0,0,0,0,0,1,0,1, each 16 cycles; tx_busy high for exactly 160 cycles.
- Loopback: instance A tx_pin drives instance B rx_pin, A sends 0x41 -> B rx_busy pulses for about 9.5 bit times, then B rx_data=8'h41. Repeat with 0x00, 0xFF and 0xA5.
- False start: rx_pin low for 4 cycles only (CLKS_PER_BIT=16) -> rx_busy rises then falls at half-bit; rx_data unchanged.
- Framing error: send 0x55 with the stop bit forced to 0 -> rx_data keeps its previous value, rx_busy returns to 0, and the next valid frame 0x3C is received correctly after the line goes high.
- TX busy handling: pulse tx_start with 0x12 mid-frame of 0x41 -> only 0x41 is sent. A pulse on the first idle cycle with 0x12 -> back-to-back frame with no gap.
